word_burst_tx: RTL and testbench

Transmit end of the 9-bit word link (flag + 8 data bits), the peer of the word-capturing receiver. Host logic loads up to DEPTH non-zero bytes into an internal buffer and pulses `start`. The block then sends each byte over a four-phase flag/ack handshake, followed by the all-zero EOF word. It sits between the host-side byte source and the link pins in the loopback/echo path.

---
 rtl/word_burst_tx_pkg.sv | 16 +
 rtl/word_buf.sv | 27 ++
 rtl/word_burst_tx.sv | 188 ++++++++++++++++++
 tb/tb_word_burst_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_burst_tx_pkg.sv
// Shared definitions for the 9-bit word link (flag + 8 data bits).
package word_burst_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSend,
      StRelease,
      StEofSend,
      StEofRelease,
      StFin
   } state_e;

   localparam logic [7:0]  EofWord = 8'h00;
   localparam int unsigned LinkW   = 9;

endpackage

// File: rtl/word_buf.sv
// DEPTH x 8 simple dual-port RAM with one write port and a registered read port.
module word_buf #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);

   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;

   // Write-first on an address collision so a prefetch never returns a stale byte.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/word_burst_tx.sv
// Burst transmitter: buffers non-zero bytes, then sends them plus an EOF word over a
// four-phase flag/ack handshake with a per-phase ack timeout.
module word_burst_tx
   import word_burst_tx_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned AW          = 8,
   parameter int unsigned ACK_TIMEOUT = 1023
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr_en,
   input  logic [7:0] i_wr_data,
   output logic       o_wr_drop,
   output logic       o_wr_full,
   input  logic       i_start,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_timeout_err,
   output logic       o_link_flag,
   output logic [7:0] o_link_data,
   input  logic       i_link_ack
);

   localparam int unsigned TW   = $clog2(ACK_TIMEOUT + 1);
   localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

   state_e        r_state;
   logic [AW:0]   r_count;
   logic [AW:0]   r_len;
   logic [AW:0]   r_idx;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_word;
   logic          r_wr_drop;
   logic          r_wr_full;
   logic          r_busy;
   logic          r_done;
   logic          r_timeout_err;
   logic          r_link_flag;
   logic [7:0]    r_link_data;

   logic          w_idle;
   logic          w_accept;
   logic          w_drop;
   logic [AW-1:0] w_raddr;
   logic [7:0]    w_rd_data;
   logic [AW:0]   w_idx_nx;
   logic          w_ack_phase;
   logic          w_rel_phase;
   logic          w_advance;
   logic          w_expired;
   logic          w_abort;

   assign w_idle   = (r_state == StIdle);
   assign w_accept = w_idle && i_wr_en && !i_start && (i_wr_data != 8'h00) && (r_count != Full);
   assign w_drop   = i_wr_en && !w_accept;
   assign w_idx_nx = r_idx + 1'b1;
   // Idle prefetches entry 0; during a burst the next entry is kept ready.
   assign w_raddr  = w_idle ? '0 : (r_idx[AW-1:0] + 1'b1);

   assign w_ack_phase = (r_state == StSend) || (r_state == StEofSend);
   assign w_rel_phase = (r_state == StRelease) || (r_state == StEofRelease);
   assign w_advance   = (w_ack_phase && i_link_ack) || (w_rel_phase && !i_link_ack);
   assign w_expired   = (r_timer == TW'(ACK_TIMEOUT - 1));
   assign w_abort     = (w_ack_phase || w_rel_phase) && !w_advance && w_expired;

   word_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .i_clk   (i_clk),
      .i_we    (w_accept),
      .i_waddr (r_count[AW-1:0]),
      .i_wdata (i_wr_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_count       <= '0;
         r_len         <= '0;
         r_idx         <= '0;
         r_timer       <= '0;
         r_word        <= EofWord;
         r_wr_drop     <= 1'b0;
         r_wr_full     <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_link_flag   <= 1'b0;
         r_link_data   <= EofWord;
      end else begin
         r_wr_drop <= w_drop;
         r_done    <= 1'b0;
         if (w_ack_phase || w_rel_phase) begin
            r_timer <= w_advance ? '0 : r_timer + 1'b1;
         end
         case (r_state)
            StIdle: begin
               r_busy      <= 1'b0;
               r_link_flag <= 1'b0;
               r_link_data <= EofWord;
               r_timer     <= '0;
               if (i_start) begin
                  r_timeout_err <= 1'b0;
                  r_len         <= r_count;
                  r_idx         <= '0;
                  r_word        <= w_rd_data;
                  r_state       <= (r_count == '0) ? StEofSend : StSend;
               end else if (w_accept) begin
                  r_count   <= r_count + 1'b1;
                  r_wr_full <= ((r_count + 1'b1) == Full);
               end
            end
            StSend: begin
               r_busy      <= 1'b1;
               r_link_flag <= 1'b1;
               r_link_data <= r_word;
               if (i_link_ack) begin
                  r_state <= StRelease;
               end
            end
            StRelease: begin
               r_busy      <= 1'b1;
               r_link_flag <= 1'b0;
               r_link_data <= r_word;
               if (!i_link_ack) begin
                  r_idx <= w_idx_nx;
                  if (w_idx_nx < r_len) begin
                     r_word  <= w_rd_data;
                     r_state <= StSend;
                  end else begin
                     r_state <= StEofSend;
                  end
               end
            end
            StEofSend: begin
               r_busy      <= 1'b1;
               r_link_flag <= 1'b1;
               r_link_data <= EofWord;
               if (i_link_ack) begin
                  r_state <= StEofRelease;
               end
            end
            StEofRelease: begin
               r_busy      <= 1'b1;
               r_link_flag <= 1'b0;
               r_link_data <= EofWord;
               if (!i_link_ack) begin
                  r_state <= StFin;
               end
            end
            StFin: begin
               r_busy      <= 1'b1;
               r_link_flag <= 1'b0;
               r_link_data <= EofWord;
               r_done      <= 1'b1;
               r_count     <= '0;
               r_wr_full   <= 1'b0;
               r_state     <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
         // Abort overrides whatever the wait state scheduled above.
         if (w_abort) begin
            r_state       <= StIdle;
            r_busy        <= 1'b0;
            r_link_flag   <= 1'b0;
            r_link_data   <= EofWord;
            r_timeout_err <= 1'b1;
            r_count       <= '0;
            r_wr_full     <= 1'b0;
            r_timer       <= '0;
         end
      end
   end

   assign o_wr_drop     = r_wr_drop;
   assign o_wr_full     = r_wr_full;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_timeout_err = r_timeout_err;
   assign o_link_flag   = r_link_flag;
   assign o_link_data   = r_link_data;

endmodule

// File: tb/tb_word_burst_tx.sv
// Bench for word_burst_tx: queue-based reference model compared every cycle, a
// programmable receiver, directed scenarios with literal expectations, then random bursts.
module tb_word_burst_tx;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 8;
   localparam int unsigned TO    = 1023;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       start = 1'b0;
   logic       link_ack = 1'b0;
   logic       o_wr_drop, o_wr_full, o_busy, o_done, o_timeout_err, o_link_flag;
   logic [7:0] o_link_data;

   word_burst_tx #(
      .DEPTH       (DEPTH),
      .AW          (AW),
      .ACK_TIMEOUT (TO)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_wr_en       (wr_en),
      .i_wr_data     (wr_data),
      .o_wr_drop     (o_wr_drop),
      .o_wr_full     (o_wr_full),
      .i_start       (start),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_timeout_err (o_timeout_err),
      .o_link_flag   (o_link_flag),
      .o_link_data   (o_link_data),
      .i_link_ack    (link_ack)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 word shown awaiting ack, 2 awaiting release,
   // 3 finishing. Decisions taken at an edge become visible on the outputs one edge later.
   int         ph  = 0;
   int         tmr = 0;
   logic [7:0] store[$];
   logic [7:0] words[$];
   logic       e_busy = 0, e_done = 0, e_err = 0, e_flag = 0, e_drop = 0, e_full = 0;
   logic [7:0] e_data = 8'h00;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph = 0; tmr = 0;
         store.delete(); words.delete();
         e_busy = 0; e_done = 0; e_err = 0; e_flag = 0; e_drop = 0; e_full = 0; e_data = 8'h00;
      end else begin
         logic drop;
         logic adv;
         drop   = 1'b0;
         e_busy = (ph != 0);
         e_flag = (ph == 1);
         e_data = (ph == 1 || ph == 2) ? words[0] : 8'h00;
         e_done = (ph == 3);
         case (ph)
            0: begin
               if (start) begin
                  e_err = 1'b0;
                  words = store;
                  words.push_back(8'h00);
                  ph = 1; tmr = 0;
                  drop = wr_en;
               end else if (wr_en) begin
                  if (wr_data != 8'h00 && store.size() < DEPTH) store.push_back(wr_data);
                  else drop = 1'b1;
               end
            end
            1, 2: begin
               drop = wr_en;
               adv  = (ph == 1) ? link_ack : !link_ack;
               if (adv) begin
                  tmr = 0;
                  if (ph == 1) ph = 2;
                  else begin
                     void'(words.pop_front());
                     ph = (words.size() != 0) ? 1 : 3;
                  end
               end else begin
                  tmr++;
                  if (tmr == TO) begin
                     ph = 0; tmr = 0;
                     e_busy = 0; e_flag = 0; e_data = 8'h00; e_err = 1;
                     store.delete(); words.delete();
                  end
               end
            end
            default: begin
               drop = wr_en;
               store.delete();
               ph = 0;
            end
         endcase
         e_drop = drop;
         e_full = (store.size() == DEPTH);
      end
   end

   // Receiver: follows the flag after rx_delay cycles; refuses to ack stall_data when stalling.
   int         rx_delay = 0;
   int         rcnt = 0;
   bit         stall_en = 0;
   logic [7:0] stall_data = 8'h00;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         link_ack = 1'b0; rcnt = 0;
      end else if (o_link_flag && stall_en && o_link_data == stall_data) begin
         rcnt = 0;
      end else if (o_link_flag != link_ack) begin
         if (rcnt >= rx_delay) begin
            link_ack = o_link_flag; rcnt = 0;
         end else rcnt++;
      end else rcnt = 0;
   end

   // Per-cycle comparison and event monitors.
   logic [13:0] act_v, exp_v;
   assign act_v = {o_busy, o_done, o_timeout_err, o_link_flag, o_wr_drop, o_wr_full, o_link_data};
   assign exp_v = {e_busy, e_done, e_err, e_flag, e_drop, e_full, e_data};

   logic [7:0] obs[$];
   int         done_cnt = 0, busy_cnt = 0, drop_cnt = 0, hi42_cnt = 0;
   logic       prev_flag = 1'b0;

   always @(negedge clk) begin
      chk("outputs_vs_model", 32'(act_v), 32'(exp_v));
      if (o_link_flag && !prev_flag) obs.push_back(o_link_data);
      prev_flag = o_link_flag;
      if (o_done) done_cnt++;
      if (o_busy) busy_cnt++;
      if (o_wr_drop) drop_cnt++;
      if (o_link_flag && o_link_data == 8'h42) hi42_cnt++;
   end

   bit rnd_wr = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] b);
      wr_en = 1'b1; wr_data = b;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clr_mon();
      obs.delete();
      done_cnt = 0; busy_cnt = 0; drop_cnt = 0; hi42_cnt = 0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((ph != 0 || o_busy) && n < budget) begin
         tick();
         if (rnd_wr) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         end
         n++;
      end
      wr_en = 1'b0;
      chk("burst_end_within_budget", {30'b0, (ph != 0), o_busy}, 32'd0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp1 [4];
      int         seen;
      int         n;
      exp1[0] = 8'h41; exp1[1] = 8'h42; exp1[2] = 8'h43; exp1[3] = 8'h00;

      tick(); tick();
      chk("reset_outputs", 32'(act_v), 32'd0);
      rst = 1'b0;
      tick();

      // Three words with a receiver answering two cycles late.
      clr_mon(); rx_delay = 2;
      load(8'h41); load(8'h42); load(8'h43);
      go();
      wait_done(400);
      chk("t1_word_count", obs.size(), 4);
      for (int i = 0; i < 4 && i < obs.size(); i++) chk("t1_word", 32'(obs[i]), 32'(exp1[i]));
      chk("t1_done_pulses", done_cnt, 1);

      // Empty burst with an immediate receiver: EOF only, busy for exactly five cycles.
      clr_mon(); rx_delay = 0;
      go();
      wait_done(50);
      chk("t2_busy_cycles", busy_cnt, 5);
      chk("t2_word_count", obs.size(), 1);
      if (obs.size() > 0) chk("t2_eof_word", 32'(obs[0]), 32'h00);
      chk("t2_done_pulses", done_cnt, 1);

      // Drops: zero byte, overflow, write with start, write while busy. Then a full burst.
      clr_mon();
      load(8'h00);
      for (int i = 0; i < DEPTH + 1; i++) begin
         load(8'((i % 255) + 1));
         if (i == DEPTH - 2) chk("t3_not_full", o_wr_full, 1'b0);
         if (i == DEPTH - 1) chk("t3_full", o_wr_full, 1'b1);
      end
      wr_en = 1'b1; wr_data = 8'h55; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      tick();
      load(8'h66);
      wait_done(3000);
      chk("t3_drop_pulses", drop_cnt, 4);
      chk("t3_word_count", obs.size(), DEPTH + 1);
      if (obs.size() == DEPTH + 1) begin
         chk("t3_word_254", 32'(obs[254]), 32'hFF);
         chk("t3_eof_word", 32'(obs[DEPTH]), 32'h00);
      end
      chk("t3_full_cleared", o_wr_full, 1'b0);

      // Receiver never acks the second word.
      clr_mon(); rx_delay = 1;
      load(8'h41); load(8'h42); load(8'h43);
      stall_en = 1; stall_data = 8'h42;
      go();
      wait_done(TO + 300);
      chk("t4_timeout_err", o_timeout_err, 1'b1);
      chk("t4_busy_low", o_busy, 1'b0);
      chk("t4_flag_low", o_link_flag, 1'b0);
      chk("t4_no_done", done_cnt, 0);
      // Wait state is entered one edge before the flag rises.
      chk("t4_flag_high_cycles", hi42_cnt, TO - 1);
      chk("t4_words_seen", obs.size(), 2);
      stall_en = 0;
      go();
      chk("t4_err_cleared", o_timeout_err, 1'b0);
      wait_done(50);

      // Asynchronous reset while word 1 is in its release phase.
      clr_mon(); rx_delay = 3;
      load(8'h41); load(8'h42);
      go();
      seen = 0; n = 0;
      while (n < 100) begin
         tick(); n++;
         if (o_link_flag) seen = 1;
         else if (seen != 0) break;
      end
      chk("t5_release_reached", {31'b0, (seen != 0 && !o_link_flag)}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_reset_outputs", 32'(act_v), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr_mon(); rx_delay = 0;
      go();
      wait_done(50);
      chk("t5_word_count", obs.size(), 1);
      if (obs.size() > 0) chk("t5_eof_word", 32'(obs[0]), 32'h00);
      chk("t5_done_pulses", done_cnt, 1);

      // Random bursts with stray writes while busy, checked against the model each cycle.
      for (int r = 0; r < 8; r++) begin
         int nl;
         rx_delay = $urandom_range(0, 3);
         nl = $urandom_range(0, 12);
         for (int k = 0; k < nl; k++) begin
            load(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
         end
         go();
         rnd_wr = 1;
         wait_done(2000);
         rnd_wr = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
